clk_tick_ctrl: RTL
==================

Name: clk_tick_ctrl

Overview:
- Runtime-programmable clock-enable controller that sequences the design's slow-clock resource.
- Replaces the fixed power-of-two divide ratio with a configurable integer period (1..2^CNT_W-1).
- Sets period changes at safe boundaries and starts/stops the slow clock cleanly.
- Produces a stretched, synchronously released reset for the slow domain.
- Sits between the board clock/reset and every block consuming the slow tick or slow clock.

Parameters:
CNT_W, 16, width of period counter and cfg_div
DEFAULT_DIV, 256, period in CLK cycles loaded at reset (must be non-zero, < 2^CNT_W)
RST_HOLD, 16, CLK cycles rst_out_n is held low after resetn deasserts (>=1)

Ports:
CLK  input  1  system clock
resetn  input  1  asynchronous active-low reset
cfg_div  input  CNT_W  requested period in CLK cycles
cfg_valid  input  1  cfg_div valid
cfg_ready  output  1  controller can accept cfg_div
run  input  1  level request to generate ticks
tick  output  1  one-CLK-cycle pulse at the last cycle of each period
sclk  output  1  registered slow clock, high for first floor(div/2) cycles of each period
busy  output  1  high in RUN or STOP
rst_out_n  output  1  stretched active-low reset for slow domain
periods  output  8  wrapping count of ticks since last IDLE->RUN

Behaviour:
- Reset (resetn low, async): state=HOLD, cnt=0, hold_cnt=0, div_active=DEFAULT_DIV, pending cleared. Outputs: tick=0, sclk=0, busy=0, cfg_ready=0, rst_out_n=0, periods=0. Reset mid-operation discards any pending config immediately.
- HOLD: hold_cnt increments each CLK. At the edge where hold_cnt reaches RST_HOLD-1, go to IDLE and set rst_out_n=1 (registered). rst_out_n stays low for exactly RST_HOLD cycles after resetn rises. cfg and run are ignored in HOLD.
- IDLE: cnt=0, tick=0, sclk=0, busy=0, cfg_ready=1.
  - cfg handshake (cfg_valid&cfg_ready): div_active<=cfg_div at that edge.
  - run=1 and div_active!=0: go to RUN with cnt=0 and periods=0. If config and run arrive in the same cycle, run sees the old div_active and the new value applies from the first period.
- RUN: cnt increments each cycle.
  - tick=1 combinationally in the cycle cnt==div_active-1; at that edge cnt<=0 and periods<=periods+1 (wraps 255->0).
  - sclk register = 1 in cycles where cnt < (div_active>>1). div_active=1 gives tick every cycle and sclk constant 0.
  - run=0: go to STOP with no counter disturbance.
- STOP: counts exactly as RUN.
  - run=1 again: return to RUN, no gap in ticks.
  - At the tick edge with run=0: go to IDLE (final tick emitted).
- Config in RUN/STOP:
  - Handshake stores cfg_div into pending; cfg_ready<=0.
  - At the next period boundary (tick edge): div_active<=pending, cfg_ready<=1.
  - Handshake in the tick cycle itself: cfg_div loads div_active directly at that edge, so the very next period uses it; cfg_ready stays 1.
- div_active becomes 0 at a boundary: go to IDLE at that edge. In IDLE, run is ignored while div_active==0.
- Ticks are never truncated or shortened; a period in progress always completes with its original length.
- Arithmetic is unsigned CNT_W bits; cnt never exceeds div_active-1.

Test Plan:
- Reset: resetn low 3 cycles then high, run=0 -> rst_out_n low for exactly 16 CLK after release then 1; cfg_ready 0 during hold, 1 after; all outputs 0 during reset.
- Default run: run=1 after hold -> first tick on 256th cycle in RUN, then every 256 cycles; sclk 128 high/128 low; periods increments 0,1,2…
- Config in IDLE: cfg_div=5 accepted, then run=1 -> tick every 5 cycles; sclk 2 high/3 low; div=1 -> tick every cycle, sclk 0.
- Mid-period reconfig: running div=10, cfg_div=4 accepted at cnt=3 -> cfg_ready drops, current period ends at cnt=9, following periods are 4 cycles, cfg_ready high again after boundary edge; same test with accept in tick cycle -> next period 4, cfg_ready never drops.
- Stop/restart: div=6, run=0 at cnt=2 -> STOP, final tick at cnt=5, IDLE, busy=0; repeat with run=1 again at cnt=4 -> ticks continue every 6 with no gap; cfg_div=0 while running -> IDLE at next boundary, run ignored.
- Async reset mid-run with pending config: outputs return to reset values without waiting for CLK; after hold, period is 256 again, pending value never applied.

Source files
------------

// File: rtl/clk_tick_ctrl.sv
// Runtime-programmable clock-enable controller.
// Generates a one-cycle tick and a registered slow clock with a configurable period.
// Period changes are applied only at period boundaries.
// Also provides a stretched, synchronously released reset for the slow domain.
module clk_tick_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 256,
    parameter int unsigned RST_HOLD    = 16
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             run,
    output logic             tick,
    output logic             sclk,
    output logic             busy,
    output logic             rst_out_n,
    output logic [7:0]       periods
);

    localparam int unsigned       HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  DIV_RST   = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {StHold, StIdle, StRun, StStop} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   div_q;
    logic [CNT_W-1:0]   pend_q;
    logic               pend_valid_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               cfg_ready_q;
    logic               rst_out_q;
    logic               sclk_q;
    logic [7:0]         periods_q;

    logic               active;
    logic               cfg_hs;
    logic               period_end;
    logic [CNT_W-1:0]   div_next;
    logic [CNT_W-1:0]   cnt_inc;

    // Decode of the current period position and the divider that applies from the next boundary
    always_comb begin
        active     = (state_q == StRun) || (state_q == StStop);
        cfg_hs     = cfg_valid && cfg_ready_q;
        period_end = active && (cnt_q == (div_q - CNT_W'(1)));
        cnt_inc    = cnt_q + CNT_W'(1);
        // A handshake can only coincide with a pending value in neither IDLE nor RUN/STOP,
        // because cfg_ready is low whenever a value is pending.
        if (cfg_hs) begin
            div_next = cfg_div;
        end else if (pend_valid_q) begin
            div_next = pend_q;
        end else begin
            div_next = div_q;
        end
    end

    // Control FSM with all outputs registered except the combinational tick
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            div_q        <= DIV_RST;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            hold_q       <= '0;
            cfg_ready_q  <= 1'b0;
            rst_out_q    <= 1'b0;
            sclk_q       <= 1'b0;
            periods_q    <= '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q     <= StIdle;
                        rst_out_q   <= 1'b1;
                        cfg_ready_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                StIdle: begin
                    cnt_q <= '0;
                    if (cfg_hs) begin
                        div_q <= cfg_div;
                    end
                    // Run qualifies on the old divider; a zero newly written alongside it
                    // must not start a period that could never end.
                    if (run && (div_q != '0) && (div_next != '0)) begin
                        state_q   <= StRun;
                        periods_q <= '0;
                        sclk_q    <= (div_next >> 1) != '0;
                    end
                end
                StRun, StStop: begin
                    if (period_end) begin
                        cnt_q        <= '0;
                        periods_q    <= periods_q + 8'd1;
                        div_q        <= div_next;
                        pend_valid_q <= 1'b0;
                        cfg_ready_q  <= 1'b1;
                        if (div_next == '0) begin
                            state_q <= StIdle;
                            sclk_q  <= 1'b0;
                        end else if ((state_q == StStop) && !run) begin
                            state_q <= StIdle;
                            sclk_q  <= 1'b0;
                        end else begin
                            state_q <= run ? StRun : StStop;
                            sclk_q  <= (div_next >> 1) != '0;
                        end
                    end else begin
                        cnt_q   <= cnt_inc;
                        state_q <= run ? StRun : StStop;
                        sclk_q  <= cnt_inc < (div_q >> 1);
                        if (cfg_hs) begin
                            pend_q       <= cfg_div;
                            pend_valid_q <= 1'b1;
                            cfg_ready_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StHold;
                end
            endcase
        end
    end

    assign tick      = period_end;
    assign sclk      = sclk_q;
    assign busy      = active;
    assign cfg_ready = cfg_ready_q;
    assign rst_out_n = rst_out_q;
    assign periods   = periods_q;

endmodule
